clk_gate_ctrl: RTL and testbench

- Sleep/wake controller that generates the functional clock enable for the core clock gate. clk_en_o drives the gate's en_i directly.
- Runs on the free-running, ungated clock.
- On a core sleep request (WFI), waits until the bus has been idle for a programmable drain window, then drops the enable.
- Restores the enable on an interrupt or debug request and holds the core stalled for a settle window before releasing it.

---
 rtl/clk_gate_ctrl.sv | 125 ++++++++++++
 tb/tb_clk_gate_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Sleep/wake controller producing the functional clock enable for the core gate.
// Runs on the free-running clock. Drains the bus before gating, then settles on wake.
module clk_gate_ctrl #(
  parameter int unsigned DrainCycles = 4,
  parameter int unsigned WakeCycles  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sleep_req_i,
  input  logic       busy_i,
  input  logic       irq_pending_i,
  input  logic       debug_req_i,
  output logic       clk_en_o,
  output logic       core_sleep_o,
  output logic       wake_o,
  output logic       abort_o,
  output logic [1:0] state_o
);

  localparam int unsigned MaxCycles =
    (DrainCycles > WakeCycles) ? DrainCycles : WakeCycles;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] DrainLast = CntW'(DrainCycles - 1);
  localparam logic [CntW-1:0] WakeLast  = CntW'(WakeCycles - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_e;

  state_e          state;
  state_e          state_n;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_n;

  logic wake_src;
  logic clk_en_n;
  logic core_sleep_n;
  logic wake_n;
  logic abort_n;

  assign wake_src = irq_pending_i | debug_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wake_n  = 1'b0;
    abort_n = 1'b0;
    case (state)
      RUN: begin
        if (sleep_req_i && !wake_src) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end
      end
      DRAIN: begin
        if (wake_src || !sleep_req_i) begin
          state_n = RUN;
          cnt_n   = '0;
          abort_n = 1'b1;
        end else if (busy_i) begin
          cnt_n = '0;
        end else if (cnt == DrainLast) begin
          state_n = SLEEP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CntOne;
        end
      end
      SLEEP: begin
        if (wake_src) begin
          state_n = WAKE;
          cnt_n   = '0;
        end
      end
      WAKE: begin
        if (cnt == WakeLast) begin
          state_n = RUN;
          cnt_n   = '0;
          wake_n  = 1'b1;
        end else begin
          cnt_n = cnt + CntOne;
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
    // Outputs follow the next state so they are registered alongside it.
    clk_en_n     = (state_n != SLEEP);
    core_sleep_n = (state_n == SLEEP) || (state_n == WAKE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_en_o     <= 1'b1;
      core_sleep_o <= 1'b0;
      wake_o       <= 1'b0;
      abort_o      <= 1'b0;
    end else begin
      clk_en_o     <= clk_en_n;
      core_sleep_o <= core_sleep_n;
      wake_o       <= wake_n;
      abort_o      <= abort_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed vector bench for clk_gate_ctrl (DrainCycles=4, WakeCycles=2).
// Table rows are applied one per clock edge; reset corners are hand-written.
module tb_clk_gate_ctrl;

  logic       clk;
  logic       rst;
  logic       sleep_req;
  logic       busy;
  logic       irq;
  logic       dbg;
  logic       clk_en;
  logic       core_sleep;
  logic       wake;
  logic       abort_p;
  logic [1:0] state;

  int n_cmp;
  int n_bad;

  typedef struct packed {
    logic       s;
    logic       b;
    logic       i;
    logic       d;
    logic       en;
    logic       sl;
    logic       wk;
    logic       ab;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  clk_gate_ctrl #(
    .DrainCycles(4),
    .WakeCycles (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sleep_req_i  (sleep_req),
    .busy_i       (busy),
    .irq_pending_i(irq),
    .debug_req_i  (dbg),
    .clk_en_o     (clk_en),
    .core_sleep_o (core_sleep),
    .wake_o       (wake),
    .abort_o      (abort_p),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic s, input logic b, input logic i,
                     input logic d, input logic en, input logic sl,
                     input logic wk, input logic ab, input logic [1:0] st);
    vec_t v;
    v = {s, b, i, d, en, sl, wk, ab, st};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {clk_en, core_sleep, wake, abort_p, state};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got en/sl/wk/ab/st=%b required %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic i,
                       input logic d);
    sleep_req = s;
    busy      = b;
    irq       = i;
    dbg       = d;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    #2;
    check("reset_values", 6'b1_0_0_0_00);
    @(negedge clk);
    rst = 1'b0;

    //   s b i d   en sl wk ab st
    add(0,0,0,0,  1, 0, 0, 0, 2'd0); // idle run
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // DRAIN cnt0
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // cnt1
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // cnt2
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // cnt3
    add(1,0,0,0,  0, 1, 0, 0, 2'd2); // edge 4: gated
    add(1,1,0,0,  0, 1, 0, 0, 2'd2); // busy ignored in SLEEP
    add(1,0,0,1,  1, 1, 0, 0, 2'd3); // debug wake: edge N
    add(1,0,0,0,  1, 1, 0, 0, 2'd3); // N+1
    add(1,0,0,0,  1, 0, 1, 0, 2'd0); // N+2: release, wake pulse
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // re-sleep into DRAIN cnt0
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // cnt1
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // cnt2
    add(1,1,0,0,  1, 0, 0, 0, 2'd1); // busy at cnt2 -> cnt0
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // idle 1
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // idle 2
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // idle 3
    add(1,0,0,0,  0, 1, 0, 0, 2'd2); // idle 4: gated
    add(0,0,1,0,  1, 1, 0, 0, 2'd3); // irq wake
    add(0,0,0,0,  1, 1, 0, 0, 2'd3);
    add(0,0,0,0,  1, 0, 1, 0, 2'd0); // wake pulse
    add(0,0,0,0,  1, 0, 0, 0, 2'd0); // pulse is one cycle
    add(1,0,1,0,  1, 0, 0, 0, 2'd0); // simultaneous sleep+irq
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // DRAIN cnt0
    add(1,0,0,0,  1, 0, 0, 0, 2'd1);
    add(1,0,0,0,  1, 0, 0, 0, 2'd1);
    add(1,0,0,0,  1, 0, 0, 0, 2'd1); // cnt3
    add(1,0,1,0,  1, 0, 0, 1, 2'd0); // irq on final count: abort
    add(0,0,0,0,  1, 0, 0, 0, 2'd0); // abort one cycle
    add(1,0,0,0,  1, 0, 0, 0, 2'd1);
    add(0,0,0,0,  1, 0, 0, 1, 2'd0); // sleep dropped: abort
    add(0,0,0,0,  1, 0, 0, 0, 2'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].s, vecs[k].b, vecs[k].i, vecs[k].d);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k),
            {vecs[k].en, vecs[k].sl, vecs[k].wk, vecs[k].ab, vecs[k].st});
    end

    // Async reset while gated: outputs recover without a clock edge.
    drive(1, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_sleep", 6'b0_1_0_0_10);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_sleep", 6'b1_0_0_0_00);
    @(negedge clk);
    check("reset_held", 6'b1_0_0_0_00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_drain", 6'b1_0_0_0_01);

    // Async reset during WAKE.
    repeat (4) @(posedge clk);
    #1;
    check("resleep_gated", 6'b0_1_0_0_10);
    drive(0, 0, 1, 0);
    @(posedge clk);
    #1;
    check("wake_entry", 6'b1_1_0_0_11);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_wake", 6'b1_0_0_0_00);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("post_reset_idle", 6'b1_0_0_0_00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
